// File: rtl/reg_rename_file_pkg.sv
// Shared constants for the rename register file and the ROB that uses the
// same widths: data width, tag width, ROB depth, register-index width and
// single-bit true/false constants.
package reg_rename_file_pkg;

  localparam int XLEN     = 32;           // architectural register width
  localparam int TAG_W    = 4;            // ROB index width
  localparam int ROB_SIZE = 1 << TAG_W;   // 16-entry ROB
  localparam int REG_W    = 5;            // architectural register index width
  localparam int NREG     = 1 << REG_W;   // 32 architectural registers

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

endpackage : reg_rename_file_pkg

// File: rtl/reg_rename_file_read_port.sv
// rename_read_port: combinational priority mux for one source operand.
// Given the looked-up state of the addressed register and the ROB commit
// inputs, produces either a usable value (ready=1) or the pending producer's
// ROB tag zero-extended onto the value bus (ready=0).
// Ports:
//   addr                 source register index
//   reg_busy/tag/val     state of register 'addr'
//   commit_en/rd/tag/val same-cycle ROB retirement (bypass source)
//   ready                operand value is available
//   val                  value when ready, else {zeros, tag}
module rename_read_port
  import reg_rename_file_pkg::*;
#(
  parameter int XLEN  = reg_rename_file_pkg::XLEN,
  parameter int TAG_W = reg_rename_file_pkg::TAG_W
) (
  input  logic [REG_W-1:0] addr,
  input  logic             reg_busy,
  input  logic [TAG_W-1:0] reg_tag,
  input  logic [XLEN-1:0]  reg_val,
  input  logic             commit_en,
  input  logic [REG_W-1:0] commit_rd,
  input  logic [TAG_W-1:0] commit_tag,
  input  logic [XLEN-1:0]  commit_val,
  output logic             ready,
  output logic [XLEN-1:0]  val
);

  logic w_bypass;

  // Only the commit of the *current* producer may forward; an older tag
  // retiring to the same register does not make the operand ready.
  assign w_bypass = commit_en && (commit_rd == addr) && (commit_tag == reg_tag);

  // NOTE: every output gets a default first so no path through the
  // if/else chain leaves a value held, which would infer a latch.
  always_comb begin
    ready = TRUE;
    val   = '0;
    if (addr == '0) begin
      ready = TRUE;
      val   = '0;
    end else if (!reg_busy) begin
      ready = TRUE;
      val   = reg_val;
    end else if (w_bypass) begin
      ready = TRUE;
      val   = commit_val;
    end else begin
      ready = FALSE;
      val   = {{(XLEN-TAG_W){1'b0}}, reg_tag};
    end
  end

endmodule : rename_read_port

// File: rtl/reg_rename_file.sv
// reg_rename_file: architectural register file with per-register rename
// tags. Dispatch marks a destination busy under a ROB tag; in-order commit
// writes the value and releases the tag if it is still the latest producer.
// Two combinational read ports return either a value or the pending tag.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   rdy               global enable; low holds all state
//   flush             clears every busy bit (misprediction)
//   issue_en/rd/tag   dispatch renames rd to tag
//   commit_en/rd/tag/val  ROB retirement of a register-writing op
//   rs1_*/rs2_*       source read ports (addr in, ready/val out)
module reg_rename_file
  import reg_rename_file_pkg::*;
#(
  parameter int NREG  = reg_rename_file_pkg::NREG,
  parameter int XLEN  = reg_rename_file_pkg::XLEN,
  parameter int TAG_W = reg_rename_file_pkg::TAG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             flush,
  input  logic             issue_en,
  input  logic [REG_W-1:0] issue_rd,
  input  logic [TAG_W-1:0] issue_tag,
  input  logic             commit_en,
  input  logic [REG_W-1:0] commit_rd,
  input  logic [TAG_W-1:0] commit_tag,
  input  logic [XLEN-1:0]  commit_val,
  input  logic [REG_W-1:0] rs1_addr,
  input  logic [REG_W-1:0] rs2_addr,
  output logic             rs1_ready,
  output logic [XLEN-1:0]  rs1_val,
  output logic             rs2_ready,
  output logic [XLEN-1:0]  rs2_val
);

  logic [XLEN-1:0]  r_val  [NREG];
  logic [TAG_W-1:0] r_tag  [NREG];
  logic [NREG-1:0]  r_busy;

  logic w_commit;
  logic w_issue;

  assign w_commit = commit_en && (commit_rd != '0);
  // A flush drops any issue presented in the same cycle.
  assign w_issue  = issue_en && !flush && (issue_rd != '0);

  // NOTE: the value array is reset as well as the busy/tag state, because
  // reads of a never-written register must return 0 after reset.
  // NOTE: non-blocking assignments only; the issue update is placed after
  // the commit update so that, on the same register, the later
  // assignment (busy set) overrides commit's busy clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= '0;
      for (int i = 0; i < NREG; i++) begin
        r_val[i] <= '0;
        r_tag[i] <= '0;
      end
    end else if (rdy) begin
      if (w_commit) begin
        r_val[commit_rd] <= commit_val;
        if (r_tag[commit_rd] == commit_tag)
          r_busy[commit_rd] <= FALSE;
      end
      if (flush) begin
        r_busy <= '0;
      end else if (w_issue) begin
        r_busy[issue_rd] <= TRUE;
        r_tag[issue_rd]  <= issue_tag;
      end
    end
  end

  rename_read_port #(.XLEN(XLEN), .TAG_W(TAG_W)) u_rs1 (
    .addr       (rs1_addr),
    .reg_busy   (r_busy[rs1_addr]),
    .reg_tag    (r_tag[rs1_addr]),
    .reg_val    (r_val[rs1_addr]),
    .commit_en  (commit_en),
    .commit_rd  (commit_rd),
    .commit_tag (commit_tag),
    .commit_val (commit_val),
    .ready      (rs1_ready),
    .val        (rs1_val)
  );

  rename_read_port #(.XLEN(XLEN), .TAG_W(TAG_W)) u_rs2 (
    .addr       (rs2_addr),
    .reg_busy   (r_busy[rs2_addr]),
    .reg_tag    (r_tag[rs2_addr]),
    .reg_val    (r_val[rs2_addr]),
    .commit_en  (commit_en),
    .commit_rd  (commit_rd),
    .commit_tag (commit_tag),
    .commit_val (commit_val),
    .ready      (rs2_ready),
    .val        (rs2_val)
  );

endmodule : reg_rename_file

// File: tb/tb_reg_rename_file.sv
// Self-checking bench for reg_rename_file: a directed cycle table with
// hand-derived expectations, a reset/rdy corner sequence, then randomized
// traffic compared against a behavioural model of the register file.
module tb_reg_rename_file;

  localparam int XLEN  = 32;
  localparam int TAG_W = 4;
  localparam int NREG  = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             rdy;
  logic             flush;
  logic             issue_en;
  logic [4:0]       issue_rd;
  logic [TAG_W-1:0] issue_tag;
  logic             commit_en;
  logic [4:0]       commit_rd;
  logic [TAG_W-1:0] commit_tag;
  logic [XLEN-1:0]  commit_val;
  logic [4:0]       rs1_addr;
  logic [4:0]       rs2_addr;
  logic             rs1_ready;
  logic [XLEN-1:0]  rs1_val;
  logic             rs2_ready;
  logic [XLEN-1:0]  rs2_val;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  reg_rename_file #(.NREG(NREG), .XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .rdy        (rdy),
    .flush      (flush),
    .issue_en   (issue_en),
    .issue_rd   (issue_rd),
    .issue_tag  (issue_tag),
    .commit_en  (commit_en),
    .commit_rd  (commit_rd),
    .commit_tag (commit_tag),
    .commit_val (commit_val),
    .rs1_addr   (rs1_addr),
    .rs2_addr   (rs2_addr),
    .rs1_ready  (rs1_ready),
    .rs1_val    (rs1_val),
    .rs2_ready  (rs2_ready),
    .rs2_val    (rs2_val)
  );

  task automatic check(input string name, input logic [XLEN-1:0] act,
                       input logic [XLEN-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic             rdy;
    logic             flush;
    logic             ie;
    logic [4:0]       ird;
    logic [TAG_W-1:0] itag;
    logic             ce;
    logic [4:0]       crd;
    logic [TAG_W-1:0] ctag;
    logic [XLEN-1:0]  cval;
    logic [4:0]       a1;
    logic [4:0]       a2;
    logic             e1r;
    logic [XLEN-1:0]  e1v;
    logic             e2r;
    logic [XLEN-1:0]  e2v;
  } vec_t;

  function automatic vec_t mk(
      input logic rd_, input logic fl, input logic ie, input int ird, input int itag,
      input logic ce, input int crd, input int ctag, input logic [XLEN-1:0] cval,
      input int a1, input int a2,
      input logic e1r, input logic [XLEN-1:0] e1v,
      input logic e2r, input logic [XLEN-1:0] e2v);
    vec_t v;
    v.rdy = rd_; v.flush = fl;
    v.ie = ie; v.ird = 5'(ird); v.itag = TAG_W'(itag);
    v.ce = ce; v.crd = 5'(crd); v.ctag = TAG_W'(ctag); v.cval = cval;
    v.a1 = 5'(a1); v.a2 = 5'(a2);
    v.e1r = e1r; v.e1v = e1v; v.e2r = e2r; v.e2v = e2v;
    return v;
  endfunction

  localparam int NVEC = 18;
  vec_t tbl [NVEC];

  task automatic drive_idle();
    rst = 0; rdy = 1; flush = 0;
    issue_en = 0; issue_rd = '0; issue_tag = '0;
    commit_en = 0; commit_rd = '0; commit_tag = '0; commit_val = '0;
    rs1_addr = '0; rs2_addr = '0;
  endtask

  task automatic do_reset();
    drive_idle();
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  // ---------------- behavioural model ----------------
  logic [XLEN-1:0]  m_val  [NREG];
  logic [TAG_W-1:0] m_tag  [NREG];
  logic             m_busy [NREG];

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) begin
      m_val[i] = '0; m_tag[i] = '0; m_busy[i] = 1'b0;
    end
  endtask

  function automatic logic [XLEN:0] model_read(input logic [4:0] a);
    // returns {ready, value}
    if (a == 0) return {1'b1, {XLEN{1'b0}}};
    if (!m_busy[a]) return {1'b1, m_val[a]};
    if (commit_en && commit_rd == a && commit_tag == m_tag[a]) return {1'b1, commit_val};
    return {1'b0, XLEN'(m_tag[a])};
  endfunction

  // Next state of every register, computed from the current inputs.
  task automatic model_step();
    logic [XLEN-1:0]  nv [NREG];
    logic [TAG_W-1:0] nt [NREG];
    logic             nb [NREG];
    bit commit_hit, issue_hit;
    if (rst) begin
      model_reset();
      return;
    end
    if (!rdy) return;
    for (int r = 1; r < NREG; r++) begin
      commit_hit = commit_en && commit_rd == r;
      issue_hit  = issue_en && !flush && issue_rd == r;
      nv[r] = commit_hit ? commit_val : m_val[r];
      nt[r] = issue_hit ? issue_tag : m_tag[r];
      if (flush)                              nb[r] = 1'b0;
      else if (issue_hit)                     nb[r] = 1'b1;
      else if (commit_hit && commit_tag == m_tag[r]) nb[r] = 1'b0;
      else                                    nb[r] = m_busy[r];
    end
    for (int r = 1; r < NREG; r++) begin
      m_val[r] = nv[r]; m_tag[r] = nt[r]; m_busy[r] = nb[r];
    end
  endtask

  task automatic check_vs_model(input string tagname);
    logic [XLEN:0] e1, e2;
    e1 = model_read(rs1_addr);
    e2 = model_read(rs2_addr);
    check({tagname, " rs1_ready"}, XLEN'(rs1_ready), XLEN'(e1[XLEN]));
    check({tagname, " rs1_val"},   rs1_val,          e1[XLEN-1:0]);
    check({tagname, " rs2_ready"}, XLEN'(rs2_ready), XLEN'(e2[XLEN]));
    check({tagname, " rs2_val"},   rs2_val,          e2[XLEN-1:0]);
  endtask

  initial begin
    //                rdy fl ie ird it ce crd ct cval       a1 a2 e1r e1v        e2r e2v
    tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 32'h0,    5, 0, 1, 32'h0,    1, 32'h0);
    tbl[1]  = mk(1, 0, 0, 0, 0, 1, 5, 0, 32'h1234, 5, 0, 1, 32'h0,    1, 32'h0);
    tbl[2]  = mk(1, 0, 1, 3, 7, 0, 0, 0, 32'h0,    5, 3, 1, 32'h1234, 1, 32'h0);
    tbl[3]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 32'h0,    3, 5, 0, 32'h7,    1, 32'h1234);
    tbl[4]  = mk(1, 0, 0, 0, 0, 1, 3, 7, 32'hDEAD, 3, 3, 1, 32'hDEAD, 1, 32'hDEAD);
    tbl[5]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 32'h0,    3, 0, 1, 32'hDEAD, 1, 32'h0);
    tbl[6]  = mk(1, 0, 1, 4, 2, 0, 0, 0, 32'h0,    4, 3, 1, 32'h0,    1, 32'hDEAD);
    tbl[7]  = mk(1, 0, 1, 4, 9, 0, 0, 0, 32'h0,    4, 4, 0, 32'h2,    0, 32'h2);
    tbl[8]  = mk(1, 0, 0, 0, 0, 1, 4, 2, 32'h11,   4, 4, 0, 32'h9,    0, 32'h9);
    tbl[9]  = mk(1, 0, 0, 0, 0, 1, 4, 9, 32'h22,   4, 3, 1, 32'h22,   1, 32'hDEAD);
    tbl[10] = mk(1, 0, 1, 6, 5, 1, 6, 1, 32'h77,   4, 6, 1, 32'h22,   1, 32'h0);
    tbl[11] = mk(1, 0, 1, 8, 3, 0, 0, 0, 32'h0,    6, 8, 0, 32'h5,    1, 32'h0);
    tbl[12] = mk(1, 1, 1,11, 6, 1,10, 0, 32'h55,   8,10, 0, 32'h3,    1, 32'h0);
    tbl[13] = mk(1, 0, 0, 0, 0, 0, 0, 0, 32'h0,    8,10, 1, 32'h0,    1, 32'h55);
    tbl[14] = mk(1, 0, 0, 0, 0, 0, 0, 0, 32'h0,   11, 6, 1, 32'h0,    1, 32'h77);
    tbl[15] = mk(1, 0, 1, 0, 4, 1, 0, 0, 32'hFF,   0, 0, 1, 32'h0,    1, 32'h0);
    tbl[16] = mk(0, 0, 1, 2, 1, 1, 2, 0, 32'h99,   0, 2, 1, 32'h0,    1, 32'h0);
    tbl[17] = mk(1, 0, 0, 0, 0, 0, 0, 0, 32'h0,    2, 0, 1, 32'h0,    1, 32'h0);

    do_reset();

    // Directed table: inputs applied after the edge, outputs sampled mid-cycle.
    for (int i = 0; i < NVEC; i++) begin
      rdy = tbl[i].rdy; flush = tbl[i].flush;
      issue_en = tbl[i].ie; issue_rd = tbl[i].ird; issue_tag = tbl[i].itag;
      commit_en = tbl[i].ce; commit_rd = tbl[i].crd;
      commit_tag = tbl[i].ctag; commit_val = tbl[i].cval;
      rs1_addr = tbl[i].a1; rs2_addr = tbl[i].a2;
      #3;
      check($sformatf("tbl%0d rs1_ready", i), XLEN'(rs1_ready), XLEN'(tbl[i].e1r));
      check($sformatf("tbl%0d rs1_val", i),   rs1_val,          tbl[i].e1v);
      check($sformatf("tbl%0d rs2_ready", i), XLEN'(rs2_ready), XLEN'(tbl[i].e2r));
      check($sformatf("tbl%0d rs2_val", i),   rs2_val,          tbl[i].e2v);
      @(posedge clk); #1;
    end

    // Hand sequence: busy register held across rdy low, then synchronous
    // reset must clear it even with rdy low.
    drive_idle();
    issue_en = 1; issue_rd = 5'd9; issue_tag = 4'd12;
    @(posedge clk); #1;
    drive_idle();
    rdy = 0; commit_en = 1; commit_rd = 5'd9; commit_tag = 4'd12; commit_val = 32'hAB;
    rs1_addr = 5'd9;
    #3 check("rdylow bypass ready", XLEN'(rs1_ready), 32'd1);
    check("rdylow bypass val", rs1_val, 32'hAB);
    @(posedge clk); #1;
    commit_en = 0;
    #3 check("rdylow still busy", XLEN'(rs1_ready), 32'd0);
    check("rdylow tag", rs1_val, 32'd12);
    rst = 1;
    @(posedge clk); #1;
    rst = 0; rdy = 1;
    #3 check("post-reset ready", XLEN'(rs1_ready), 32'd1);
    check("post-reset val", rs1_val, 32'd0);
    @(posedge clk); #1;

    // Randomized traffic against the behavioural model.
    do_reset();
    model_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst        = ($urandom_range(0, 499) == 0);
      rdy        = ($urandom_range(0, 9) != 0);
      flush      = ($urandom_range(0, 24) == 0);
      issue_en   = ($urandom_range(0, 1) == 1);
      issue_rd   = 5'($urandom_range(0, 7));
      issue_tag  = TAG_W'($urandom);
      commit_en  = ($urandom_range(0, 1) == 1);
      commit_rd  = 5'($urandom_range(0, 7));
      commit_tag = ($urandom_range(0, 3) != 0) ? m_tag[commit_rd] : TAG_W'($urandom);
      commit_val = $urandom;
      rs1_addr   = ($urandom_range(0, 3) == 0) ? commit_rd : 5'($urandom_range(0, 7));
      rs2_addr   = 5'($urandom_range(0, 31));
      #3;
      check_vs_model($sformatf("rnd%0d", cyc));
      model_step();
      @(posedge clk); #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_reg_rename_file
